// File: rtl/gb_write_packer_pkg.sv
// rtl/gb_write_packer_pkg.sv - shared types, defaults and lane-select helper for the global buffer write packer
package gb_write_packer_pkg;

   typedef enum logic [0:0] {
      S_FILL,
      S_ISSUE
   } gb_packer_state_t;

   localparam int GB_DEFAULT_DEPTH = 16;

   function automatic logic lane_sel(input int unsigned ptr, input int unsigned lane);
      return ptr == lane;
   endfunction

endpackage

// File: rtl/gb_write_packer.sv
// rtl/gb_write_packer.sv - packs dataSize elements into interfaceDepth-wide lines for the global buffer write port
// Optional statistics counters enabled by defining GB_PACKER_STATS_EN.
module gb_write_packer
   import gb_write_packer_pkg::*;
#(
   parameter int dataSize       = 8,
   parameter int interfaceDepth = GB_DEFAULT_DEPTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [dataSize-1:0]                in_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               flush_i,
   output logic [interfaceDepth*dataSize-1:0] wr_data,
   output logic                               wr_en,
   input  logic                               ready_i,
   output logic                               busy_o
`ifdef GB_PACKER_STATS_EN
   ,
   output logic [31:0]                        line_count_o,
   output logic [31:0]                        pad_count_o
`endif
);

   localparam int interfaceWidth = interfaceDepth * dataSize;
   localparam int PTR_W = (interfaceDepth > 1) ? $clog2(interfaceDepth) : 1;
   localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(interfaceDepth - 1);

   gb_packer_state_t          state;
   logic [PTR_W-1:0]          lane_ptr;
   logic [interfaceWidth-1:0] line_q;
   logic [interfaceWidth-1:0] line_next;
   logic                      pending_flush;
   logic                      accept;
   logic                      fill_done;
   logic                      do_flush;
   logic                      issue_done;

   assign in_ready   = (state == S_FILL) && !rst;
   assign accept     = in_valid && in_ready;
   assign fill_done  = accept && (lane_ptr == LAST_LANE);
   // An empty line is only flushed if this same cycle contributes an element.
   assign do_flush   = flush_i && (state == S_FILL) && (accept || (lane_ptr != '0));
   assign issue_done = (state == S_ISSUE) && wr_en && ready_i;
   assign busy_o     = (lane_ptr != '0) || wr_en;

   always_comb begin
      line_next = line_q;
      for (int i = 0; i < interfaceDepth; i++) begin
         if (accept && lane_sel(32'(lane_ptr), unsigned'(i))) begin
            line_next[i*dataSize +: dataSize] = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_FILL;
         lane_ptr      <= '0;
         line_q        <= '0;
         pending_flush <= 1'b0;
         wr_en         <= 1'b0;
         wr_data       <= '0;
      end else begin
         case (state)
            S_FILL: begin
               line_q <= line_next;
               if (accept) begin
                  lane_ptr <= lane_ptr + 1'b1;
               end
               if (fill_done || do_flush) begin
                  state    <= S_ISSUE;
                  lane_ptr <= '0;
                  wr_en    <= 1'b1;
                  wr_data  <= line_next;
               end
            end
            S_ISSUE: begin
               // Nothing is accepted while issuing, so a flush here is already covered by this line.
               pending_flush <= pending_flush || (flush_i && (lane_ptr != '0));
               if (issue_done) begin
                  state         <= S_FILL;
                  wr_en         <= 1'b0;
                  wr_data       <= '0;
                  line_q        <= '0;
                  pending_flush <= 1'b0;
               end
            end
            default: begin
               state <= S_FILL;
            end
         endcase
      end
   end

`ifdef GB_PACKER_STATS_EN
   logic [31:0] pad_lanes;

   assign pad_lanes = 32'(interfaceDepth) - 32'(lane_ptr) - {31'b0, accept};

   always_ff @(posedge clk) begin
      if (rst) begin
         line_count_o <= '0;
         pad_count_o  <= '0;
      end else begin
         if (issue_done) begin
            line_count_o <= line_count_o + 32'd1;
         end
         if (do_flush && !fill_done) begin
            pad_count_o <= pad_count_o + pad_lanes;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gb_write_packer.sv
// tb/tb_gb_write_packer.sv - directed vector bench for gb_write_packer
module tb_gb_write_packer;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         flush_i;
   logic [127:0] wr_data;
   logic         wr_en;
   logic         ready_i;
   logic         busy_o;
`ifdef GB_PACKER_STATS_EN
   logic [31:0]  line_count_o;
   logic [31:0]  pad_count_o;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gb_write_packer #(
      .dataSize       (8),
      .interfaceDepth (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .flush_i  (flush_i),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .ready_i  (ready_i),
      .busy_o   (busy_o)
`ifdef GB_PACKER_STATS_EN
      ,
      .line_count_o (line_count_o),
      .pad_count_o  (pad_count_o)
`endif
   );

   typedef struct {
      logic         rst;
      logic         valid;
      logic [7:0]   data;
      logic         flush;
      logic         ready;
      logic         exp_in_ready;
      logic         exp_wr_en;
      logic         exp_busy;
      logic [127:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] base, input int n, input bit flush_last);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = base + 8'(i);
         flush_i  = flush_last && (i == n - 1);
         tick();
      end
      in_valid = 1'b0;
      flush_i  = 1'b0;
   endtask

   initial begin
      int hi;
      int lines;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush_i = 1'b0; ready_i = 1'b0;

      // rst valid data flush ready | in_ready wr_en busy wr_data
      vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0});
      vecs.push_back('{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 128'h0});
      vecs.push_back('{1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 128'h0});
      vecs.push_back('{1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 128'h0});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 128'hCCBBAA});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 128'hCCBBAA});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0});
      vecs.push_back('{1'b0, 1'b1, 8'hDD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 128'hDD});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0});

      for (int v = 0; v < vecs.size(); v++) begin
         rst      = vecs[v].rst;
         in_valid = vecs[v].valid;
         in_data  = vecs[v].data;
         flush_i  = vecs[v].flush;
         ready_i  = vecs[v].ready;
         tick();
         check($sformatf("vec%0d_in_ready", v), {127'b0, in_ready}, {127'b0, vecs[v].exp_in_ready});
         check($sformatf("vec%0d_wr_en", v), {127'b0, wr_en}, {127'b0, vecs[v].exp_wr_en});
         check($sformatf("vec%0d_busy", v), {127'b0, busy_o}, {127'b0, vecs[v].exp_busy});
         check($sformatf("vec%0d_wr_data", v), wr_data, vecs[v].exp_data);
      end
      in_valid = 1'b0; flush_i = 1'b0;

      // Full line streamed with the buffer always ready.
      ready_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         check($sformatf("t1_ready_lane%0d", i), {127'b0, in_ready}, 128'h1);
         tick();
      end
      in_valid = 1'b0;
      check("t1_in_ready_low", {127'b0, in_ready}, 128'h0);
      check("t1_wr_en", {127'b0, wr_en}, 128'h1);
      check("t1_wr_data", wr_data, 128'h0F0E0D0C0B0A09080706050403020100);
      tick();
      check("t1_in_ready_back", {127'b0, in_ready}, 128'h1);
      check("t1_wr_en_low", {127'b0, wr_en}, 128'h0);

      // Backpressure: five stalled cycles, then a handshake; held element waits.
      ready_i = 1'b0;
      send(8'h10, 16, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      hi = 0;
      for (int c = 0; c < 20 && wr_en; c++) begin
         hi++;
         check($sformatf("t2_data_c%0d", hi), wr_data, 128'h1F1E1D1C1B1A19181716151413121110);
         check($sformatf("t2_in_ready_c%0d", hi), {127'b0, in_ready}, 128'h0);
         ready_i = (hi == 6);
         tick();
      end
      check("t2_wr_en_cycles", 128'(hi), 128'd6);
      check("t2_in_ready_resume", {127'b0, in_ready}, 128'h1);
      tick();
      in_valid = 1'b0;
      check("t2_busy_held", {127'b0, busy_o}, 128'h1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("t2_held_wr_en", {127'b0, wr_en}, 128'h1);
      check("t2_held_data", wr_data, 128'hEE);
      tick();
      check("t2_idle_busy", {127'b0, busy_o}, 128'h0);

      // Flush coincident with the 16th accept: one line only.
      send(8'h30, 16, 1'b1);
      check("t4_wr_en", {127'b0, wr_en}, 128'h1);
      check("t4_wr_data", wr_data, 128'h3F3E3D3C3B3A39383736353433323130);
      lines = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (wr_en) lines++;
      end
      check("t4_extra_lines", 128'(lines), 128'd0);

      // Reset during issue and during a partial fill.
      ready_i = 1'b0;
      send(8'h40, 16, 1'b0);
      check("t5_issue_wr_en", {127'b0, wr_en}, 128'h1);
      rst = 1'b1;
      tick();
      check("t5_rst_wr_en", {127'b0, wr_en}, 128'h0);
      check("t5_rst_busy", {127'b0, busy_o}, 128'h0);
      check("t5_rst_in_ready", {127'b0, in_ready}, 128'h0);
      rst = 1'b0;
      ready_i = 1'b1;
      send(8'hF0, 8, 1'b0);
      check("t5_partial_busy", {127'b0, busy_o}, 128'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_rst2_busy", {127'b0, busy_o}, 128'h0);
      check("t5_rst2_wr_en", {127'b0, wr_en}, 128'h0);
      send(8'h80, 16, 1'b0);
      check("t5_clean_wr_en", {127'b0, wr_en}, 128'h1);
      check("t5_clean_data", wr_data, 128'h8F8E8D8C8B8A89888786858483828180);
      tick();

`ifdef GB_PACKER_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_line_count_rst", 128'(line_count_o), 128'd0);
      send(8'h00, 16, 1'b0);
      tick();
      send(8'h20, 16, 1'b0);
      tick();
      send(8'h50, 4, 1'b0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      tick();
      check("t6_line_count", 128'(line_count_o), 128'd3);
      check("t6_pad_count", 128'(pad_count_o), 128'd12);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
